lockin_result_buffer: RTL
=========================

# lockin_result_buffer

Result buffer directly downstream of `signal_processing`. Pairs the in-phase (`data_out1`) and quadrature (`data_out2`) 64-bit lock-in results into single entries and stores them in a FIFO. Exposes them to the HPS-side register bridge through a pop/readback handshake, with occupancy, status flags and an end-of-acquisition indication.

## Interface
Parameters:
- `DEPTH`, 256: FIFO entries; must be a power of two.
- `ADDR_W`, 8: log2(`DEPTH`).

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `enable`  in  1  acquisition enable (same source as `enable_gral`).
- `clear`  in  1  one-cycle synchronous flush of FIFO, pending register, flags and FSM.
- `fase_in`  in  64  signed in-phase result.
- `fase_valid`  in  1  `fase_in` qualifier, one cycle per result.
- `cuad_in`  in  64  signed quadrature result.
- `cuad_valid`  in  1  `cuad_in` qualifier, one cycle per result.
- `processing_finished`  in  1  end-of-calculation level from `signal_processing`.
- `rd_pop`  in  1  request the oldest pair.
- `rd_fase`  out  64  popped in-phase value.
- `rd_cuad`  out  64  popped quadrature value.
- `rd_valid`  out  1  one-cycle qualifier for `rd_fase`/`rd_cuad`.
- `count`  out  ADDR_W+1  stored pairs, 0..DEPTH.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky: a pair was dropped because the FIFO was full.
- `sync_error`  out  1  sticky: a second result of one channel arrived before its partner.
- `done`  out  1  high in FLUSHED state.

## Operation
- FSM states: IDLE, CAPTURE, FLUSHED.
  - IDLE -> CAPTURE when `enable` is 1.
  - CAPTURE -> FLUSHED on the first cycle with `processing_finished` = 1.
  - CAPTURE -> IDLE when `enable` is 0. The pending half is discarded; FIFO contents are kept.
  - FLUSHED -> IDLE only on `clear` or reset.
  - `clear` forces IDLE from any state and overrides every other event that cycle.
- Inputs are accepted only in CAPTURE, including the cycle in which `processing_finished` rises. Valids are ignored in IDLE and FLUSHED.
- Pairing:
  - `fase_valid` and `cuad_valid` in the same cycle: write `{fase_in, cuad_in}` directly.
  - Only one channel valid: store that half in a pending register and set its pending flag. The pair is written when the partner arrives.
  - A channel's valid arrives while its own half is already pending: set `sync_error` and overwrite the pending value. No write occurs.
  - Partner arrives in the same cycle as a new value for the pending channel: write the pending value with the partner, then hold the new value as pending.
- FIFO:
  - Circular buffer; write and read pointers of `ADDR_W` bits wrap modulo `DEPTH`.
  - Write when full: the pair is dropped, `overflow` is set and pointers are unchanged.
  - Pop and write in the same cycle when full: both happen, no overflow, `count` unchanged.
  - Pop when empty: ignored, `rd_valid` stays 0, nothing changes.
  - Pop and write in the same cycle when empty: the write is stored and the pop is ignored.
- Data is stored unmodified, full 64 bits; no arithmetic is applied to the samples.
- `overflow` and `sync_error` clear only on `clear` or reset.

## Timing
- Reset (`reset_n` = 0 at a rising edge): state IDLE. Pointers, `count` and pending flags are 0. `rd_fase`, `rd_cuad`, `rd_valid`, `overflow`, `sync_error` and `done` are 0. `empty` is 1 and `full` is 0.
- Reset asserted mid-acquisition discards everything. There is no partial retention.
- Write latency: a pair accepted at edge k is reflected in `count`/`empty` after edge k. It is poppable from cycle k+1.
- Read latency: `rd_pop` sampled at edge k gives `rd_fase`/`rd_cuad`/`rd_valid` registered at edge k, i.e. one cycle after the request. `rd_valid` is a one-cycle pulse per successful pop.
- Back-to-back pops, one per cycle, are supported at full rate.
- `rd_fase`/`rd_cuad` hold their last value when `rd_valid` is 0.
- `done` rises one cycle after `processing_finished` is sampled in CAPTURE.
- All flags are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, `enable` = 1, 4 simultaneous pairs (fase = 1..4, cuad = -1..-4), then 4 pops: `rd_valid` pulses 1 cycle after each pop, data is (1,-1) .. (4,-4) in order, `count` goes 4 -> 0, `empty` = 1.
- Split arrival: fase = 10 at cycle 0, cuad = 20 at cycle 3: `count` is 0 until after the cycle-3 edge, then 1; pop returns (10,20). Then fase = 5, fase = 6 with no cuad between: `sync_error` = 1, and cuad = 7 yields the pair (6,7).
- Fill 256 pairs, write a 257th (fase = 999): `full` = 1, `overflow` = 1, `count` = 256. Pop and write (fase = 1000) in the same cycle: `count` stays 256, `overflow` unchanged. The first pop returns pair 0, and the last stored pair is 1000.
- Pointer wrap: 300 pair writes interleaved with pops, keeping `count` ≤ 10: all values return in order across the wrap and no flag sets.
- `processing_finished` pulses in the same cycle as a pair (fase = 7, cuad = 8): that pair is stored, `done` = 1 the next cycle, and later valids are ignored. `clear` gives `count` = 0, flags 0, `done` = 0, state IDLE.
- Pop on an empty FIFO: `rd_valid` stays 0. `reset_n` = 0 mid-acquisition with 5 entries stored: all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/lockin_result_buffer.sv
// ---------------------------------------------------------------------------
// lockin_result_buffer
//
// Sits directly after signal_processing. Joins each in-phase (fase) and
// quadrature (cuad) lock-in result into one 128-bit entry and queues the
// entries in a circular FIFO. The HPS register bridge drains the FIFO
// through a pop/readback handshake.
//
// Ports:
//   clk, reset_n          system clock, synchronous active-low reset
//   enable                acquisition enable (IDLE -> CAPTURE)
//   clear                 one-cycle flush of FIFO, pending halves, flags, FSM
//   fase_in/fase_valid    in-phase result and its one-cycle qualifier
//   cuad_in/cuad_valid    quadrature result and its one-cycle qualifier
//   processing_finished   end-of-calculation level (CAPTURE -> FLUSHED)
//   rd_pop                request the oldest pair
//   rd_fase/rd_cuad       popped pair, held between pops
//   rd_valid              one-cycle pulse, one cycle after an accepted pop
//   count/empty/full      FIFO occupancy, 0..DEPTH
//   overflow              sticky: a pair was dropped on a full FIFO
//   sync_error            sticky: a channel repeated before its partner came
//   done                  high while in FLUSHED
// ---------------------------------------------------------------------------
module lockin_result_buffer #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              clear,
   input  logic [63:0]       fase_in,
   input  logic              fase_valid,
   input  logic [63:0]       cuad_in,
   input  logic              cuad_valid,
   input  logic              processing_finished,
   input  logic              rd_pop,
   output logic [63:0]       rd_fase,
   output logic [63:0]       rd_cuad,
   output logic              rd_valid,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              full,
   output logic              overflow,
   output logic              sync_error,
   output logic              done
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CAPTURE = 2'd1;
   localparam logic [1:0] S_FLUSHED = 2'd2;

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

   logic [1:0]        state;
   logic [1:0]        state_next;

   logic [63:0]       pend_fase;
   logic [63:0]       pend_cuad;
   logic              pend_fase_vld;
   logic              pend_cuad_vld;
   logic [63:0]       pend_fase_next;
   logic [63:0]       pend_cuad_next;
   logic              pend_fase_vld_next;
   logic              pend_cuad_vld_next;
   logic              sync_err_set;

   logic              wr_req;
   logic [127:0]      wr_pair;
   logic              wr_ok;
   logic              pop_ok;

   logic [127:0]      mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;

   // Next-state logic. clear wins over everything; in CAPTURE the end of
   // processing takes priority over a simultaneous drop of enable so that
   // the acquisition is still reported as finished.
   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = S_IDLE;
      end else begin
         case (state)
            S_IDLE:    if (enable) state_next = S_CAPTURE;
            S_CAPTURE: begin
               if (processing_finished) state_next = S_FLUSHED;
               else if (!enable)        state_next = S_IDLE;
            end
            S_FLUSHED: state_next = S_FLUSHED;
            default:   state_next = S_IDLE;
         endcase
      end
   end

   // Pairing of the two channels. A lone half waits in its pending register
   // until the partner shows up. When the partner arrives together with a
   // fresh value for the pending channel, the older pending value is paired
   // first and the fresh one becomes the new pending half, so no sample is
   // lost and ordering is preserved.
   always_comb begin
      wr_req             = 1'b0;
      wr_pair            = {fase_in, cuad_in};
      pend_fase_next     = pend_fase;
      pend_cuad_next     = pend_cuad;
      pend_fase_vld_next = pend_fase_vld;
      pend_cuad_vld_next = pend_cuad_vld;
      sync_err_set       = 1'b0;
      if (state == S_CAPTURE && !clear) begin
         if (fase_valid && cuad_valid) begin
            wr_req = 1'b1;
            if (pend_fase_vld) begin
               wr_pair        = {pend_fase, cuad_in};
               pend_fase_next = fase_in;
            end else if (pend_cuad_vld) begin
               wr_pair        = {fase_in, pend_cuad};
               pend_cuad_next = cuad_in;
            end
         end else if (fase_valid) begin
            if (pend_fase_vld) begin
               sync_err_set   = 1'b1;
               pend_fase_next = fase_in;
            end else if (pend_cuad_vld) begin
               wr_req             = 1'b1;
               wr_pair            = {fase_in, pend_cuad};
               pend_cuad_vld_next = 1'b0;
            end else begin
               pend_fase_next     = fase_in;
               pend_fase_vld_next = 1'b1;
            end
         end else if (cuad_valid) begin
            if (pend_cuad_vld) begin
               sync_err_set   = 1'b1;
               pend_cuad_next = cuad_in;
            end else if (pend_fase_vld) begin
               wr_req             = 1'b1;
               wr_pair            = {pend_fase, cuad_in};
               pend_fase_vld_next = 1'b0;
            end else begin
               pend_cuad_next     = cuad_in;
               pend_cuad_vld_next = 1'b1;
            end
         end
      end
      if (state_next == S_IDLE) begin
         pend_fase_vld_next = 1'b0;
         pend_cuad_vld_next = 1'b0;
      end
   end

   // A pop only succeeds on a non-empty FIFO. A write into a full FIFO is
   // still taken when a pop frees a slot in the same cycle.
   always_comb begin
      pop_ok = rd_pop && (count != '0) && !clear;
      wr_ok  = wr_req && ((count != FULL_COUNT) || pop_ok);
   end

   // Control registers: FSM, pending halves, pointers, occupancy, sticky
   // flags and the registered read port.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         pend_fase     <= '0;
         pend_cuad     <= '0;
         pend_fase_vld <= 1'b0;
         pend_cuad_vld <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         overflow      <= 1'b0;
         sync_error    <= 1'b0;
         rd_fase       <= '0;
         rd_cuad       <= '0;
         rd_valid      <= 1'b0;
      end else if (clear) begin
         state         <= S_IDLE;
         pend_fase_vld <= 1'b0;
         pend_cuad_vld <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         overflow      <= 1'b0;
         sync_error    <= 1'b0;
         rd_valid      <= 1'b0;
      end else begin
         state         <= state_next;
         pend_fase     <= pend_fase_next;
         pend_cuad     <= pend_cuad_next;
         pend_fase_vld <= pend_fase_vld_next;
         pend_cuad_vld <= pend_cuad_vld_next;
         if (sync_err_set)     sync_error <= 1'b1;
         if (wr_req && !wr_ok) overflow   <= 1'b1;
         if (wr_ok)            wr_ptr     <= wr_ptr + 1'b1;
         if (pop_ok)           rd_ptr     <= rd_ptr + 1'b1;
         if (wr_ok && !pop_ok)      count <= count + 1'b1;
         else if (pop_ok && !wr_ok) count <= count - 1'b1;
         rd_valid <= pop_ok;
         if (pop_ok) begin
            rd_fase <= mem[rd_ptr][127:64];
            rd_cuad <= mem[rd_ptr][63:0];
         end
      end
   end

   // Storage array, kept out of reset so it maps onto block RAM. Stale
   // contents are unreachable because the pointers and count are reset.
   always_ff @(posedge clk) begin
      if (wr_ok && reset_n) mem[wr_ptr] <= wr_pair;
   end

   assign empty = (count == '0);
   assign full  = (count == FULL_COUNT);
   assign done  = (state == S_FLUSHED);

endmodule
